// File: rtl/ysyx_22040759_if_axi_bridge_pkg.sv
// Shared definitions for the instruction-fetch AXI bridge: fetch sizes,
// AXI constants, controller states and the size-to-mask helper.
package ysyx_22040759_if_axi_bridge_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } fetch_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_AR   = 2'b01,
    ST_R    = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  function automatic logic [63:0] size_mask(input fetch_size_e sz);
    case (sz)
      SZ_B:    size_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    size_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040759_fetch_align.sv
// Right-aligns the addressed bytes of a 64-bit read beat and zero-extends
// them to the requested fetch width.
module ysyx_22040759_fetch_align
  import ysyx_22040759_if_axi_bridge_pkg::*;
(
  input  logic [63:0]  i_data,
  input  logic [2:0]   i_offset,
  input  fetch_size_e  i_size,
  output logic [63:0]  o_data
);

  logic [63:0] w_shifted;

  assign w_shifted = i_data >> {i_offset, 3'b000};
  assign o_data    = w_shifted & size_mask(i_size);

endmodule

// File: rtl/ysyx_22040759_if_axi_bridge.sv
// Bridges single IF-stage fetch requests onto one AXI read transaction at a
// time and returns the aligned data with a one-cycle completion pulse.
module ysyx_22040759_if_axi_bridge
  import ysyx_22040759_if_axi_bridge_pkg::*;
#(
  parameter int AXI_ID_W = 4,
  parameter int FETCH_ID = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [63:0]         inst_addr,
  input  logic [1:0]          if_size,
  output logic                if_ready,
  output logic [63:0]         if_data_read,
  output logic [1:0]          if_resp,
  output logic                axi_ar_valid,
  input  logic                axi_ar_ready,
  output logic [63:0]         axi_ar_addr,
  output logic [AXI_ID_W-1:0] axi_ar_id,
  output logic [7:0]          axi_ar_len,
  output logic [2:0]          axi_ar_size,
  output logic [1:0]          axi_ar_burst,
  output logic                axi_r_ready,
  input  logic                axi_r_valid,
  input  logic [63:0]         axi_r_data,
  input  logic [1:0]          axi_r_resp,
  input  logic                axi_r_last,
  input  logic [AXI_ID_W-1:0] axi_r_id
);

  localparam logic [AXI_ID_W-1:0] LP_FETCH_ID = AXI_ID_W'(FETCH_ID);

  state_e      r_state;
  logic [63:0] r_addr;
  fetch_size_e r_size;
  logic        r_ar_valid;
  logic        r_r_ready;
  logic        r_if_ready;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  logic [63:0] w_aligned;
  logic        w_beat_hit;

  // Only the final beat of our own ID completes the fetch; other IDs are drained.
  assign w_beat_hit = axi_r_valid && (axi_r_id == LP_FETCH_ID) && axi_r_last;

  ysyx_22040759_fetch_align u_align (
    .i_data   (axi_r_data),
    .i_offset (r_addr[2:0]),
    .i_size   (r_size),
    .o_data   (w_aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_size     <= SZ_B;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
      r_if_ready <= 1'b0;
      r_data     <= '0;
      r_resp     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (if_valid) begin
            r_addr     <= inst_addr;
            r_size     <= fetch_size_e'(if_size);
            r_ar_valid <= 1'b1;
            r_state    <= ST_AR;
          end
        end
        ST_AR: begin
          if (axi_ar_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= ST_R;
          end
        end
        ST_R: begin
          if (w_beat_hit) begin
            r_r_ready  <= 1'b0;
            r_if_ready <= 1'b1;
            r_data     <= w_aligned;
            r_resp     <= axi_r_resp;
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_if_ready <= 1'b0;
          r_data     <= '0;
          r_resp     <= '0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_ready     = r_if_ready;
  assign if_data_read = r_data;
  assign if_resp      = r_resp;

  assign axi_ar_valid = r_ar_valid;
  assign axi_ar_addr  = {r_addr[63:3], 3'b000};
  assign axi_ar_id    = LP_FETCH_ID;
  assign axi_ar_len   = AXI_LEN_SINGLE;
  assign axi_ar_size  = AXI_SIZE_8B;
  assign axi_ar_burst = AXI_BURST_INCR;
  assign axi_r_ready  = r_r_ready;

endmodule

// File: tb/tb_ysyx_22040759_if_axi_bridge.sv
// Randomized and directed bench for the IF AXI bridge, checked every cycle
// against a transaction-level model of the fetch protocol.
module tb_ysyx_22040759_if_axi_bridge;

  localparam int IDW = 4;
  localparam int FID = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic [63:0]    data;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           if_valid = 1'b0;
  logic [63:0]    inst_addr = '0;
  logic [1:0]     if_size = '0;
  logic           if_ready;
  logic [63:0]    if_data_read;
  logic [1:0]     if_resp;
  logic           axi_ar_valid;
  logic           axi_ar_ready = 1'b0;
  logic [63:0]    axi_ar_addr;
  logic [IDW-1:0] axi_ar_id;
  logic [7:0]     axi_ar_len;
  logic [2:0]     axi_ar_size;
  logic [1:0]     axi_ar_burst;
  logic           axi_r_ready;
  logic           axi_r_valid = 1'b0;
  logic [63:0]    axi_r_data = '0;
  logic [1:0]     axi_r_resp = '0;
  logic           axi_r_last = 1'b0;
  logic [IDW-1:0] axi_r_id = '0;

  ysyx_22040759_if_axi_bridge #(.AXI_ID_W(IDW), .FETCH_ID(FID)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .inst_addr(inst_addr), .if_size(if_size),
    .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
    .axi_ar_burst(axi_ar_burst), .axi_r_ready(axi_r_ready), .axi_r_valid(axi_r_valid),
    .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
    .axi_r_id(axi_r_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level expectation: what the IF side and AR/R handshakes must show.
  logic        m_busy = 1'b0;
  logic        e_arv = 1'b0;
  logic        e_rr = 1'b0;
  logic        e_rdy = 1'b0;
  logic [63:0] e_data = '0;
  logic [1:0]  e_resp = '0;
  logic [63:0] m_addr = '0;
  logic [1:0]  m_size = '0;
  int          hs_cnt = 0;
  logic [63:0] hs_addr = '0;

  function automatic logic [63:0] exp_align(input logic [63:0] d, input logic [2:0] off,
                                            input logic [1:0] sz);
    logic [63:0] res;
    int nb;
    res = '0;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++)
      if (int'(off) + i < 8) res[8*i +: 8] = d[8*(int'(off)+i) +: 8];
    return res;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0; e_arv <= 1'b0; e_rr <= 1'b0; e_rdy <= 1'b0;
      e_data <= '0; e_resp <= '0; m_addr <= '0; m_size <= '0;
    end else if (e_rdy) begin
      e_rdy <= 1'b0; e_data <= '0; e_resp <= '0; m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (if_valid) begin
        m_busy <= 1'b1; m_addr <= inst_addr; m_size <= if_size; e_arv <= 1'b1;
      end
    end else if (e_arv) begin
      if (axi_ar_ready) begin
        e_arv <= 1'b0; e_rr <= 1'b1;
      end
    end else if (axi_r_valid && axi_r_id == IDW'(FID) && axi_r_last) begin
      e_rr <= 1'b0; e_rdy <= 1'b1;
      e_data <= exp_align(axi_r_data, m_addr[2:0], m_size);
      e_resp <= axi_r_resp;
    end
    if (!rst && axi_ar_valid && axi_ar_ready) begin
      hs_cnt  <= hs_cnt + 1;
      hs_addr <= axi_ar_addr;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          p_cnt = 0;
  int          p_cyc = 0;
  logic [63:0] p_data = '0;
  logic [1:0]  p_resp = '0;
  int          p_hist[$];
  beat_t       bq[$];
  int          cfg_ar_dly = 0;
  int          cfg_r_dly = 0;
  int          ar_cnt = 0;
  int          r_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock step: compare against the model, record pulses, then drive the AXI slave.
  task automatic tick();
    @(negedge clk);
    if (cyc > 0) begin
      check("if_ready", {63'd0, if_ready}, {63'd0, e_rdy});
      check("if_data_read", if_data_read, e_data);
      check("if_resp", {62'd0, if_resp}, {62'd0, e_resp});
      check("ar_valid", {63'd0, axi_ar_valid}, {63'd0, e_arv});
      check("r_ready", {63'd0, axi_r_ready}, {63'd0, e_rr});
      if (e_arv) check("ar_addr", axi_ar_addr, {m_addr[63:3], 3'b000});
      check("ar_len", {56'd0, axi_ar_len}, 64'd0);
      check("ar_size", {61'd0, axi_ar_size}, 64'd3);
      check("ar_burst", {62'd0, axi_ar_burst}, 64'd1);
      check("ar_id", {60'd0, axi_ar_id}, 64'(FID));
    end
    if (if_ready === 1'b1) begin
      p_cnt++; p_cyc = cyc; p_data = if_data_read; p_resp = if_resp;
      p_hist.push_back(cyc);
    end
    if (axi_ar_valid === 1'b1) begin
      if (ar_cnt >= cfg_ar_dly) axi_ar_ready = 1'b1;
      else begin axi_ar_ready = 1'b0; ar_cnt++; end
    end else begin
      axi_ar_ready = 1'b0; ar_cnt = 0;
    end
    if (axi_r_valid) begin
      axi_r_valid = 1'b0; axi_r_last = 1'b0;
      if (bq.size() > 0) bq.delete(0);
      r_cnt = 0;
    end
    if (axi_r_ready === 1'b1 && bq.size() > 0) begin
      if (r_cnt >= cfg_r_dly) begin
        axi_r_valid = 1'b1; axi_r_last = 1'b1;
        axi_r_id = bq[0].id; axi_r_resp = bq[0].resp; axi_r_data = bq[0].data;
      end else r_cnt++;
    end else if (axi_r_ready !== 1'b1) r_cnt = 0;
    #1;
  endtask

  task automatic push_beat(input logic [IDW-1:0] id, input logic [1:0] resp, input logic [63:0] d);
    beat_t b;
    b.id = id; b.resp = resp; b.data = d;
    bq.push_back(b);
  endtask

  task automatic wait_pulse(input int pc0, input int lim, input bit toggle, output bit got);
    got = 1'b0;
    for (int k = 0; k < lim && !got; k++) begin
      if (toggle) begin inst_addr = ~inst_addr; if_size = if_size + 2'd1; end
      tick();
      if (p_cnt != pc0) begin got = 1'b1; if_valid = 1'b0; end
    end
    check("pulse_timeout", {63'd0, got}, 64'd1);
  endtask

  int t0, pc0, hs0, hb;
  bit got, keep;
  int nwrong;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("rst_if_ready", {63'd0, if_ready}, 64'd0);
    check("rst_data", if_data_read, 64'd0);
    check("rst_ar_valid", {63'd0, axi_ar_valid}, 64'd0);
    check("rst_r_ready", {63'd0, axi_r_ready}, 64'd0);
    tick();

    // Minimum-latency word fetch, low and high word of the same doubleword.
    push_beat(IDW'(FID), 2'd0, 64'h0000001300000093);
    inst_addr = 64'h80000000; if_size = 2'b10; if_valid = 1'b1; t0 = cyc; pc0 = p_cnt;
    tick(); if_valid = 1'b0;
    wait_pulse(pc0, 20, 1'b0, got);
    check("r21_latency", 64'(p_cyc - t0), 64'd3);
    check("r21_data", p_data, 64'h00000093);
    check("r21_ar_addr", hs_addr, 64'h80000000);
    tick();

    push_beat(IDW'(FID), 2'd0, 64'h0000001300000093);
    inst_addr = 64'h80000004; if_size = 2'b10; if_valid = 1'b1; pc0 = p_cnt;
    tick(); if_valid = 1'b0;
    wait_pulse(pc0, 20, 1'b0, got);
    check("r22_data", p_data, 64'h00000013);
    check("r22_ar_addr", hs_addr, 64'h80000000);
    tick();

    // Slow AR channel while the IF side keeps changing its address.
    cfg_ar_dly = 5;
    push_beat(IDW'(FID), 2'd0, 64'h8877665544332211);
    inst_addr = 64'h80000006; if_size = 2'b01; if_valid = 1'b1; t0 = cyc; pc0 = p_cnt;
    tick(); if_valid = 1'b0;
    wait_pulse(pc0, 30, 1'b1, got);
    check("r23_latency", 64'(p_cyc - t0), 64'd8);
    check("r23_data", p_data, 64'h8877);
    check("r23_ar_addr", hs_addr, 64'h80000000);
    repeat (5) tick();
    check("r23_single_pulse", 64'(p_cnt - pc0), 64'd1);
    cfg_ar_dly = 0;

    // Foreign-ID beat first, then our beat carrying SLVERR.
    push_beat(4'd1, 2'd0, 64'h1111111111111111);
    push_beat(IDW'(FID), 2'd2, 64'hA5A5_5A5A_0123_4567);
    inst_addr = 64'h80000000; if_size = 2'b11; if_valid = 1'b1; pc0 = p_cnt;
    tick(); if_valid = 1'b0;
    wait_pulse(pc0, 20, 1'b0, got);
    check("r24_resp", {62'd0, p_resp}, 64'd2);
    check("r24_data", p_data, 64'hA5A5_5A5A_0123_4567);
    tick();

    // Reset while waiting for read data, then a clean fetch.
    bq.delete();
    inst_addr = 64'h80000020; if_size = 2'b10; if_valid = 1'b1;
    tick(); if_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (axi_r_ready === 1'b1) got = 1'b1;
    end
    check("r25_reached_r", {63'd0, got}, 64'd1);
    rst = 1'b1;
    tick();
    check("r25_r_ready", {63'd0, axi_r_ready}, 64'd0);
    check("r25_if_ready", {63'd0, if_ready}, 64'd0);
    check("r25_ar_valid", {63'd0, axi_ar_valid}, 64'd0);
    rst = 1'b0;
    tick();
    push_beat(IDW'(FID), 2'd0, 64'hDEADBEEF_CAFEF00D);
    inst_addr = 64'h80000010; if_size = 2'b10; if_valid = 1'b1; t0 = cyc; pc0 = p_cnt;
    tick(); if_valid = 1'b0;
    wait_pulse(pc0, 20, 1'b0, got);
    check("r25_latency", 64'(p_cyc - t0), 64'd3);
    check("r25_data", p_data, 64'hCAFEF00D);
    tick();

    // Three back-to-back fetches with if_valid held high.
    for (int i = 0; i < 3; i++) push_beat(IDW'(FID), 2'd0, 64'h0000001300000093);
    inst_addr = 64'h80000000; if_size = 2'b10; if_valid = 1'b1;
    pc0 = p_cnt; hs0 = hs_cnt; hb = p_hist.size();
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (if_ready === 1'b1) inst_addr = inst_addr + 64'd4;
      if (p_cnt - pc0 == 3) begin got = 1'b1; if_valid = 1'b0; end
    end
    check("r26_done", {63'd0, got}, 64'd1);
    repeat (5) tick();
    check("r26_pulses", 64'(p_cnt - pc0), 64'd3);
    check("r26_handshakes", 64'(hs_cnt - hs0), 64'd3);
    if (p_hist.size() >= hb + 3) begin
      check("r26_gap1", 64'(p_hist[hb+1] - p_hist[hb]), 64'd4);
      check("r26_gap2", 64'(p_hist[hb+2] - p_hist[hb+1]), 64'd4);
    end else check("r26_hist", 64'(p_hist.size() - hb), 64'd3);

    // Randomized fetches: foreign beats, delays, responses and a wandering IF address.
    for (int t = 0; t < 40; t++) begin
      bq.delete();
      nwrong = $urandom_range(0, 2);
      for (int w = 0; w < nwrong; w++)
        push_beat(IDW'($urandom_range(1, 15)), 2'($urandom_range(0, 3)), {$urandom, $urandom});
      push_beat(IDW'(FID), 2'($urandom_range(0, 3)), {$urandom, $urandom});
      cfg_ar_dly = $urandom_range(0, 4);
      cfg_r_dly = $urandom_range(0, 3);
      keep = 1'($urandom_range(0, 1));
      inst_addr = {$urandom, $urandom}; if_size = 2'($urandom_range(0, 3));
      if_valid = 1'b1; pc0 = p_cnt;
      tick();
      if (!keep) if_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 100 && !got; k++) begin
        inst_addr = {$urandom, $urandom}; if_size = 2'($urandom_range(0, 3));
        tick();
        if (p_cnt != pc0) begin got = 1'b1; if_valid = 1'b0; end
      end
      check("rand_pulse", {63'd0, got}, 64'd1);
      tick();
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
